// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers {pc, insn} in order, hands them to decode.
// Optional macro FETCHQ_BYPASS_EN lets a response reach decode in the same cycle when the queue is empty.
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = 32'h0100_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       req_o,
    output logic [AWIDTH-1:0]          addr_o,
    input  logic                       rvalid_i,
    input  logic [DWIDTH-1:0]          rdata_i,
    input  logic                       redirect_i,
    input  logic [AWIDTH-1:0]          redirect_pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = PW + 3;

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] qpc_q [DEPTH];
    logic [AWIDTH-1:0] qpc_d [DEPTH];
    logic [DWIDTH-1:0] qinsn_q [DEPTH];
    logic [DWIDTH-1:0] qinsn_d [DEPTH];
    logic [AWIDTH-1:0] tag_q [DEPTH];
    logic [AWIDTH-1:0] tag_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]     count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;

    logic [SW-1:0]     occupancy;
    logic [CW-1:0]     outstanding;
    logic              issue, resp_drop, resp_live, empty, bypass, pop, pop_queue, push;

    // Slots are reserved at issue time, so a live response always has room.
    always_comb begin
        occupancy   = SW'(count_q) + SW'(inflight_q) + SW'(drop_q);
        outstanding = drop_q + inflight_q;
        issue       = rst & ~redirect_i & (occupancy < SW'(DEPTH));
        resp_drop   = rvalid_i & (drop_q != '0);
        resp_live   = rvalid_i & (drop_q == '0) & (inflight_q != '0);
        empty       = (count_q == '0);
`ifdef FETCHQ_BYPASS_EN
        bypass      = empty & resp_live;
`else
        bypass      = 1'b0;
`endif
        valid_o     = ~redirect_i & (~empty | bypass);
        pc_o        = bypass ? tag_q[tag_rd_q] : qpc_q[head_q];
        insn_o      = bypass ? rdata_i : qinsn_q[head_q];
        pop         = valid_o & ready_i;
        pop_queue   = pop & ~empty;
        push        = resp_live & ~redirect_i & ~(bypass & ready_i);
        req_o       = issue;
        addr_o      = pc_q;
        count_o     = count_q;
    end

    always_comb begin
        pc_d       = pc_q;
        qpc_d      = qpc_q;
        qinsn_d    = qinsn_q;
        tag_d      = tag_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_i) begin
            // Everything still out at memory becomes garbage, including a response landing now.
            head_d     = '0;
            tail_d     = '0;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            count_d    = '0;
            inflight_d = '0;
            drop_d     = (rvalid_i && outstanding != '0) ? outstanding - CW'(1) : outstanding;
            pc_d       = redirect_pc_i;
        end else begin
            if (resp_drop) drop_d = drop_q - CW'(1);
            if (resp_live) tag_rd_d = tag_rd_q + PW'(1);
            if (push) begin
                qpc_d[tail_q]   = tag_q[tag_rd_q];
                qinsn_d[tail_q] = rdata_i;
                tail_d          = tail_q + PW'(1);
            end
            if (pop_queue) head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop_queue);
            if (issue) begin
                tag_d[tag_wr_q] = pc_q;
                tag_wr_d        = tag_wr_q + PW'(1);
                pc_d            = pc_q + AWIDTH'(4);
            end
            inflight_d = inflight_q + CW'(issue) - CW'(resp_live);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qpc_q[i]   <= '0;
                qinsn_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            qpc_q      <= qpc_d;
            qinsn_q    <= qinsn_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: in-order memory with random latency and a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_o;
    logic [31:0] addr_o;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [2:0]  count_o;

    fetch_queue #(.AWIDTH(32), .DWIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0100_0000)) dut (
        .clk(clk), .rst(rst), .req_o(req_o), .addr_o(addr_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit live; } mem_req_t;
    typedef struct { logic [31:0] pc; logic [31:0] insn; } entry_t;

    mem_req_t    pend[$];
    entry_t      model_q[$];
    logic [31:0] next_pc;
    int          cyc;
    int          last_due;
    int          checks;
    int          fails;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit rdy, input int lat);
        bit       rv, byp, exp_valid, exp_req, consumed;
        entry_t   head;
        mem_req_t r;
        int       due;
        rv            = (pend.size() > 0) && (pend[0].due <= cyc);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        ready_i       = rdy;
        rvalid_i      = rv;
        rdata_i       = rv ? pend[0].data : $urandom;
        #1;
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = rv && pend[0].live && (model_q.size() == 0);
`endif
        exp_valid = !redir && ((model_q.size() > 0) || byp);
        exp_req   = !redir && ((model_q.size() + pend.size()) < DEPTH);
        checkOutput("count_o", 32'(count_o), 32'(model_q.size()));
        checkOutput("valid_o", 32'(valid_o), 32'(exp_valid));
        checkOutput("req_o", 32'(req_o), 32'(exp_req));
        if (exp_req) checkOutput("addr_o", addr_o, next_pc);
        if (exp_valid) begin
            if (model_q.size() > 0) head = model_q[0];
            else begin
                head.pc   = pend[0].addr;
                head.insn = pend[0].data;
            end
            checkOutput("pc_o", pc_o, head.pc);
            checkOutput("insn_o", insn_o, head.insn);
        end
        if (redir) begin
            model_q.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
            if (rv) r = pend.pop_front();
            next_pc = rpc;
        end else begin
            consumed = 1'b0;
            if (exp_valid && rdy) begin
                if (model_q.size() > 0) head = model_q.pop_front();
                else consumed = 1'b1;
            end
            if (rv) begin
                r = pend.pop_front();
                if (r.live && !consumed) model_q.push_back('{r.addr, r.data});
            end
            if (exp_req) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{next_pc, $urandom, due, 1'b1});
                next_pc = next_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] rpc;
        checks   = 0;
        fails    = 0;
        cyc      = 0;
        last_due = 0;
        next_pc  = 32'h0100_0000;

        #12;
        checkOutput("reset req_o", 32'(req_o), 32'd0);
        checkOutput("reset valid_o", 32'(valid_o), 32'd0);
        checkOutput("reset count_o", 32'(count_o), 32'd0);
        checkOutput("reset pc_o", pc_o, 32'd0);
        checkOutput("reset insn_o", insn_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] streaming with 1-cycle memory");
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1);

        $display("[TB] decode stalled");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b0, 1);
        checkOutput("stall count_o", 32'(count_o), 32'd4);
        checkOutput("stall req_o", 32'(req_o), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1);

        $display("[TB] redirect with fetches in flight");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 3);
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1);
        checkOutput("post-redirect count_o", 32'(count_o), 32'd0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'd0, 1'b1, 2);

        $display("[TB] redirect colliding with pop and response");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1);
        applyStimulus(1'b1, 32'h0000_4000, 1'b1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1);

        $display("[TB] back-to-back redirects and PC wrap");
        applyStimulus(1'b1, 32'h0000_8000, 1'b1, 1);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            rpc = $urandom;
            rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
            applyStimulus(($urandom_range(0, 15) == 0), rpc, 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
